// File: rtl/sqrt_flow_ctrl_if.sv
// Handshake bundle around the sqrt flow-control shell: request side, core side and result side.
// The slave view belongs to the shell; the master view is whatever surrounds it.
interface sqrt_flow_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic [WIDTH-1:0] core_N;
    logic             core_in_valid;
    logic [WIDTH-1:0] core_sqrt;
    logic             core_out_valid;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport slave (
        input  s_valid, s_data, core_sqrt, core_out_valid, m_ready,
        output s_ready, core_N, core_in_valid, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, core_sqrt, core_out_valid, m_ready,
        input  s_ready, core_N, core_in_valid, m_valid, m_data
    );
endinterface

// File: rtl/sqrt_flow_ctrl.sv
// Credit-based flow control around a fixed-latency sqrt core that has no backpressure.
// Results land in a first-word-fall-through FIFO; a post-reset window discards stale core output.
module sqrt_flow_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int CORE_LAT = 17
) (
    input  logic            clk,
    input  logic            rst,
    sqrt_flow_ctrl_if.slave bus,
    output logic            err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(CORE_LAT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [DW-1:0] LAT_C   = DW'(CORE_LAT);
    localparam logic [DW-1:0] DRN_ONE = DW'(1);

    typedef enum logic {S_DRAIN, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [DW-1:0]    r_drain_cnt, w_drain_nxt;
    logic [CW-1:0]    r_in_flight;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_err;

    logic             w_run;
    logic [CW:0]      w_committed;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_underflow;
    logic             w_overflow;
    logic             w_retire;
    logic             w_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= LAT_C;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            S_DRAIN: begin
                if (r_drain_cnt == '0) w_state_nxt = S_RUN;
                else                   w_drain_nxt = r_drain_cnt - DRN_ONE;
            end
            S_RUN: ;
        endcase
    end

    // Credit covers both buffered results and those still inside the core; a pop frees credit only next cycle.
    assign w_run       = (r_state == S_RUN);
    assign w_committed = {1'b0, r_in_flight} + {1'b0, r_count};
    assign w_s_ready   = w_run && (w_committed < {1'b0, DEPTH_C});
    assign w_accept    = bus.s_valid && w_s_ready;
    assign w_pop       = (r_count != '0) && bus.m_ready;
    assign w_full      = (r_count == DEPTH_C);
    assign w_underflow = w_run && bus.core_out_valid && (r_in_flight == '0);
    assign w_overflow  = w_run && bus.core_out_valid && w_full && !w_pop;
    assign w_retire    = w_run && bus.core_out_valid && !w_underflow;
    assign w_push      = w_retire && !w_overflow;

    assign bus.s_ready       = w_s_ready;
    assign bus.core_in_valid = w_accept;
    assign bus.core_N        = bus.s_data;
    assign bus.m_valid       = (r_count != '0);
    assign bus.m_data        = r_mem[r_rd_ptr];
    assign err               = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_flight <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept && !w_retire)      r_in_flight <= r_in_flight + CNT_ONE;
            else if (!w_accept && w_retire) r_in_flight <= r_in_flight - CNT_ONE;

            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;

            if (w_underflow || w_overflow) r_err <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.core_sqrt;
    end
endmodule

// File: tb/tb_sqrt_flow_ctrl.sv
// Bench for sqrt_flow_ctrl: two shells (DEPTH 4 and 32), each wrapped around a behavioural fixed-latency sqrt core.
`timescale 1ns/1ps
module tb_sqrt_flow_ctrl;
    localparam int WIDTH    = 16;
    localparam int CORE_LAT = 17;
    localparam int PIPE_N   = CORE_LAT + 1;

    typedef struct {
        logic [15:0] n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err4, err32;
    logic inj4 = 1'b0;
    always #5 clk = ~clk;

    sqrt_flow_ctrl_if #(.WIDTH(WIDTH)) if4 ();
    sqrt_flow_ctrl_if #(.WIDTH(WIDTH)) if32 ();

    sqrt_flow_ctrl #(.WIDTH(WIDTH), .DEPTH(4), .CORE_LAT(CORE_LAT)) u_d4 (
        .clk(clk), .rst(rst), .bus(if4), .err(err4)
    );
    sqrt_flow_ctrl #(.WIDTH(WIDTH), .DEPTH(32), .CORE_LAT(CORE_LAT)) u_d32 (
        .clk(clk), .rst(rst), .bus(if32), .err(err32)
    );

    // Exact floor(sqrt(N) * 64), i.e. Q10.6.
    function automatic logic [15:0] isqrt(input logic [15:0] n);
        logic [31:0] v, r, b;
        v = {4'b0, n, 12'b0};
        r = 32'd0;
        b = 32'h4000_0000;
        while (b > v) b = b >> 2;
        while (b != 0) begin
            if (v >= r + b) begin
                v = v - (r + b);
                r = (r >> 1) + b;
            end else begin
                r = r >> 1;
            end
            b = b >> 2;
        end
        return r[15:0];
    endfunction

    // Core models: un-resettable delay lines, out_valid rises CORE_LAT cycles after in_valid is sampled.
    logic [PIPE_N-1:0] vld4  = '0;
    logic [PIPE_N-1:0] vld32 = '0;
    logic [WIDTH-1:0]  dat4  [PIPE_N];
    logic [WIDTH-1:0]  dat32 [PIPE_N];

    always @(posedge clk) begin
        vld4     <= {vld4[PIPE_N-2:0], if4.core_in_valid};
        vld32    <= {vld32[PIPE_N-2:0], if32.core_in_valid};
        dat4[0]  <= isqrt(if4.core_N);
        dat32[0] <= isqrt(if32.core_N);
        for (int k = 1; k < PIPE_N; k++) begin
            dat4[k]  <= dat4[k-1];
            dat32[k] <= dat32[k-1];
        end
    end

    assign if4.core_out_valid  = vld4[PIPE_N-1] | inj4;
    assign if4.core_sqrt       = dat4[PIPE_N-1];
    assign if32.core_out_valid = vld32[PIPE_N-1];
    assign if32.core_sqrt      = dat32[PIPE_N-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rx4 [$];
    logic [15:0] rx32 [$];
    int          rx32_cyc [$];
    logic [15:0] tx4 [$];
    int          acc4 = 0;

    always @(negedge clk) begin
        if (if4.m_valid && if4.m_ready) rx4.push_back(if4.m_data);
        if (if32.m_valid && if32.m_ready) begin
            rx32.push_back(if32.m_data);
            rx32_cyc.push_back(cyc);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic [15:0] act, input logic [15:0] exp);
        int d;
        n_cmp++;
        d = int'(act) - int'(exp);
        if ($isunknown(act) || d > 1 || d < -1) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (+/-1)", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers the head of tx4 every cycle; leaves s_valid as it was on return.
    task automatic send_all4(input int budget);
        int c;
        c = 0;
        while (tx4.size() != 0 && c < budget) begin
            if4.s_valid = 1'b1;
            if4.s_data  = tx4[0];
            @(negedge clk);
            if (if4.s_ready) begin
                void'(tx4.pop_front());
                acc4++;
            end
            tick();
            c++;
        end
    endtask

    task automatic wait_rx4(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (rx4.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, rx4.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   c;

        vecs[0] = '{n: 16'd16,    exp: 16'h0100};
        vecs[1] = '{n: 16'd2,     exp: 16'h005A};
        vecs[2] = '{n: 16'd0,     exp: 16'h0000};
        vecs[3] = '{n: 16'd65535, exp: 16'h3FFF};
        vecs[4] = '{n: 16'd1,     exp: 16'h0040};
        vecs[5] = '{n: 16'd100,   exp: 16'h0280};
        vecs[6] = '{n: 16'd10000, exp: 16'h1900};
        vecs[7] = '{n: 16'd3,     exp: 16'h006E};
        vecs[8] = '{n: 16'd255,   exp: 16'h03FD};
        vecs[9] = '{n: 16'd4096,  exp: 16'h1000};

        if4.s_valid  = 1'b1;
        if4.s_data   = 16'd5;
        if4.m_ready  = 1'b0;
        if32.s_valid = 1'b0;
        if32.s_data  = 16'd0;
        if32.m_ready = 1'b0;

        // Reset state, with a request already offered.
        @(negedge clk);
        chk1("rst_s_ready",       if4.s_ready,       1'b0);
        chk1("rst_core_in_valid", if4.core_in_valid, 1'b0);
        chk1("rst_m_valid",       if4.m_valid,       1'b0);
        chk1("rst_err",           err4,              1'b0);
        chk1("rst_s_ready32",     if32.s_ready,      1'b0);
        tick();
        rst = 1'b0;
        if4.s_valid = 1'b0;
        c = 0;
        while (!if4.s_ready && c < 40) begin
            tick();
            c++;
        end
        chk1("drain_exit", if4.s_ready, 1'b1);

        // T1: latency and value of a single request.
        rx4.delete();
        if4.s_valid = 1'b1;
        if4.s_data  = 16'd16;
        @(negedge clk);
        chk1("t1_accept", if4.s_ready, 1'b1);
        tick();
        if4.s_valid = 1'b0;
        repeat (CORE_LAT) tick();
        @(negedge clk);
        chk1("t1_m_valid_early", if4.m_valid, 1'b0);
        tick();
        @(negedge clk);
        chk1("t1_m_valid", if4.m_valid, 1'b1);
        chk("t1_m_data", int'(if4.m_data), 32'h0100);
        chk1("t1_err", err4, 1'b0);
        tick();
        if4.m_ready = 1'b1;
        wait_rx4(1, 5, "t1_pop");

        // T2: table of values through DEPTH=4, in order.
        rx4.delete();
        for (int i = 0; i < 10; i++) tx4.push_back(vecs[i].n);
        send_all4(400);
        if4.s_valid = 1'b0;
        chk("t2_all_accepted", tx4.size(), 0);
        wait_rx4(10, 100, "t2_count");
        for (int i = 0; i < 10; i++)
            if (i < rx4.size()) chk_tol($sformatf("t2_vec%0d", i), rx4[i], vecs[i].exp);

        // T3: backpressure with the consumer stalled.
        rx4.delete();
        acc4 = 0;
        if4.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) tx4.push_back(vecs[i].n);
        send_all4(30);
        chk("t3_accepted_stalled", acc4, 4);
        @(negedge clk);
        chk1("t3_s_ready_low", if4.s_ready, 1'b0);
        chk1("t3_m_valid", if4.m_valid, 1'b1);
        chk_tol("t3_head", if4.m_data, vecs[0].exp);
        tick();
        if4.m_ready = 1'b1;
        send_all4(300);
        if4.s_valid = 1'b0;
        chk("t3_all_accepted", tx4.size(), 0);
        wait_rx4(10, 100, "t3_count");
        for (int i = 0; i < 10; i++)
            if (i < rx4.size()) chk_tol($sformatf("t3_vec%0d", i), rx4[i], vecs[i].exp);
        chk1("t3_err", err4, 1'b0);

        // T4: streaming through DEPTH=32.
        rx32.delete();
        rx32_cyc.delete();
        if32.m_ready = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if32.s_valid = 1'b1;
            if32.s_data  = 16'(i * 655);
            @(negedge clk);
            if (!if32.s_ready) ok = 1'b0;
            tick();
        end
        if32.s_valid = 1'b0;
        chk1("t4_s_ready_held", ok, 1'b1);
        c = 0;
        while (rx32.size() < 100 && c < 200) begin
            tick();
            c++;
        end
        chk("t4_count", rx32.size(), 100);
        for (int i = 0; i < 100; i++)
            if (i < rx32.size()) chk_tol($sformatf("t4_res%0d", i), rx32[i], isqrt(16'(i * 655)));
        if (rx32.size() == 100) chk("t4_span", rx32_cyc[99] - rx32_cyc[0], 99);
        chk1("t4_err", err32, 1'b0);

        // T5: reset with three requests in flight.
        rx4.delete();
        tx4.push_back(16'd1);
        tx4.push_back(16'd100);
        tx4.push_back(16'd10000);
        send_all4(20);
        if4.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if4.s_valid = 1'b1;
        if4.s_data  = 16'd100;
        ok = 1'b1;
        for (int k = 0; k < CORE_LAT + 1; k++) begin
            @(negedge clk);
            if (if4.s_ready || if4.m_valid || if4.core_in_valid) ok = 1'b0;
            tick();
        end
        chk1("t5_drain_quiet", ok, 1'b1);
        @(negedge clk);
        chk1("t5_drain_exit", if4.s_ready, 1'b1);
        chk("t5_stale_dropped", rx4.size(), 0);
        tick();
        if4.s_valid = 1'b0;
        wait_rx4(1, 40, "t5_post_count");
        if (rx4.size() == 1) chk_tol("t5_post_data", rx4[0], 16'h0280);
        chk1("t5_err", err4, 1'b0);

        // T6: spurious core output with nothing in flight.
        tick();
        inj4 = 1'b1;
        tick();
        inj4 = 1'b0;
        @(negedge clk);
        chk1("t6_err_set", err4, 1'b1);
        chk1("t6_m_valid", if4.m_valid, 1'b0);
        repeat (5) tick();
        @(negedge clk);
        chk1("t6_err_sticky", err4, 1'b1);
        chk1("t6_s_ready", if4.s_ready, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("t6_err_cleared", err4, 1'b0);
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
